rgb565_to_ycbcr_packer: RTL and testbench

Converts a stream of RGB565 pixels into the level-shifted YCbCr byte stream consumed by `YCbCr2RGB_converter`: per 128-pixel block, 128 Y bytes, then 64 Cb bytes, then 64 Cr bytes. Chroma is subsampled 2:1 horizontally. The block sits on the capture/compression side of the frame-buffer demo and feeds the compressor. Two ping-pong banks let one block fill while the previous one drains.

---
 rtl/rgb565_to_ycbcr_packer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_rgb565_to_ycbcr_packer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb565_to_ycbcr_packer.sv
// RGB565 to level-shifted YCbCr byte packer, 128-pixel blocks,
// 4:2:2 horizontal chroma, ping-pong banks feeding the compressor.
module rgb565_to_ycbcr_packer (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        RGB_en,
    input  logic [15:0] RGB_Data,
    output logic        pixel_ready,
    output logic        compress_data_en,
    output logic [7:0]  compress_data,
    output logic        block_done
);

    typedef enum logic [1:0] {
        B_FREE,
        B_FILLING,
        B_FULL,
        B_DRAIN
    } bank_st_e;

    bank_st_e st_q [2];
    bank_st_e st_d [2];

    logic       fill_ptr_q, fill_ptr_d;
    logic [6:0] wr_cnt_q, wr_cnt_d;

    logic        s0_vld_q, s0_vld_d;
    logic [15:0] s0_px_q, s0_px_d;
    logic        s0_bank_q, s0_bank_d;
    logic [6:0]  s0_addr_q, s0_addr_d;

    logic        s1_vld_q, s1_vld_d;
    logic        s1_bank_q, s1_bank_d;
    logic [6:0]  s1_addr_q, s1_addr_d;
    logic [15:0] s1_yr_q, s1_yg_q, s1_yb_q;
    logic [15:0] s1_br_q, s1_bg_q, s1_bb_q;
    logic [15:0] s1_rr_q, s1_rg_q, s1_rb_q;
    logic [15:0] s1_yr_d, s1_yg_d, s1_yb_d;
    logic [15:0] s1_br_d, s1_bg_d, s1_bb_d;
    logic [15:0] s1_rr_d, s1_rg_d, s1_rb_d;

    logic       s2_vld_q, s2_vld_d;
    logic       s2_bank_q, s2_bank_d;
    logic [6:0] s2_addr_q, s2_addr_d;
    logic [7:0] s2_y_q, s2_y_d;
    logic [7:0] s2_cb_q, s2_cb_d;
    logic [7:0] s2_cr_q, s2_cr_d;
    logic [7:0] ev_cb_q, ev_cb_d;
    logic [7:0] ev_cr_q, ev_cr_d;

    logic       rd_ptr_q, rd_ptr_d;
    logic       rd_act_q, rd_act_d;
    logic [7:0] rd_cnt_q, rd_cnt_d;

    logic       data_en_q, data_en_d;
    logic [7:0] data_q, data_d;
    logic       done_q, done_d;

    logic [7:0] y_mem  [2][128];
    logic [7:0] cb_mem [2][64];
    logic [7:0] cr_mem [2][64];

    logic       accept;
    logic [7:0] r8, g8, b8;
    logic signed [17:0] y_sum, cb_sum, cr_sum;
    logic [7:0] y_c, cb_c, cr_c;
    logic [7:0] rd_byte;

    function automatic logic [7:0] sat(
        input logic signed [17:0] s,
        input logic signed [17:0] off,
        input logic signed [17:0] lo,
        input logic signed [17:0] hi
    );
        logic signed [17:0] v;
        v = (s >>> 8) + off;
        if (v < lo) begin
            v = lo;
        end else if (v > hi) begin
            v = hi;
        end
        return 8'(v);
    endfunction

    assign pixel_ready = (st_q[fill_ptr_q] == B_FREE) ||
                         (st_q[fill_ptr_q] == B_FILLING);
    assign accept = RGB_en & pixel_ready;

    assign compress_data_en = data_en_q;
    assign compress_data    = data_q;
    assign block_done       = done_q;

    // Stage 1: bit-replicating expansion and constant products
    always_comb begin
        r8 = {s0_px_q[15:11], s0_px_q[15:13]};
        g8 = {s0_px_q[10:5],  s0_px_q[10:9]};
        b8 = {s0_px_q[4:0],   s0_px_q[4:2]};
        s1_vld_d  = s0_vld_q;
        s1_bank_d = s0_bank_q;
        s1_addr_d = s0_addr_q;
        s1_yr_d = {8'd0, r8} * 16'd66;
        s1_yg_d = {8'd0, g8} * 16'd129;
        s1_yb_d = {8'd0, b8} * 16'd25;
        s1_br_d = {8'd0, r8} * 16'd38;
        s1_bg_d = {8'd0, g8} * 16'd74;
        s1_bb_d = {8'd0, b8} * 16'd112;
        s1_rr_d = {8'd0, r8} * 16'd112;
        s1_rg_d = {8'd0, g8} * 16'd94;
        s1_rb_d = {8'd0, b8} * 16'd18;
    end

    // Stage 2: signed sums, clamps, and pair averaging of chroma
    always_comb begin
        y_sum  = 18'sd128 + $signed({2'b0, s1_yr_q})
               + $signed({2'b0, s1_yg_q}) + $signed({2'b0, s1_yb_q});
        cb_sum = 18'sd128 - $signed({2'b0, s1_br_q})
               - $signed({2'b0, s1_bg_q}) + $signed({2'b0, s1_bb_q});
        cr_sum = 18'sd128 + $signed({2'b0, s1_rr_q})
               - $signed({2'b0, s1_rg_q}) - $signed({2'b0, s1_rb_q});
        y_c  = sat(y_sum,  18'sd16,  18'sd16, 18'sd235);
        cb_c = sat(cb_sum, 18'sd128, 18'sd16, 18'sd240);
        cr_c = sat(cr_sum, 18'sd128, 18'sd16, 18'sd240);

        s2_vld_d  = s1_vld_q;
        s2_bank_d = s1_bank_q;
        s2_addr_d = s1_addr_q;
        s2_y_d    = y_c;
        s2_cb_d = 8'(({1'b0, ev_cb_q} + {1'b0, cb_c} + 9'd1) >> 1);
        s2_cr_d = 8'(({1'b0, ev_cr_q} + {1'b0, cr_c} + 9'd1) >> 1);
        ev_cb_d = ev_cb_q;
        ev_cr_d = ev_cr_q;
        if (s1_vld_q && !s1_addr_q[0]) begin
            ev_cb_d = cb_c;
            ev_cr_d = cr_c;
        end
    end

    always_comb begin
        rd_byte = y_mem[rd_ptr_q][rd_cnt_q[6:0]];
        if (rd_cnt_q[7]) begin
            rd_byte = rd_cnt_q[6] ? cr_mem[rd_ptr_q][rd_cnt_q[5:0]]
                                  : cb_mem[rd_ptr_q][rd_cnt_q[5:0]];
        end
    end

    // Bank bookkeeping, fill side and drain side
    always_comb begin
        st_d       = st_q;
        fill_ptr_d = fill_ptr_q;
        wr_cnt_d   = wr_cnt_q;
        s0_vld_d   = accept;
        s0_px_d    = s0_px_q;
        s0_bank_d  = s0_bank_q;
        s0_addr_d  = s0_addr_q;
        rd_ptr_d   = rd_ptr_q;
        rd_act_d   = rd_act_q;
        rd_cnt_d   = rd_cnt_q;
        done_d     = 1'b0;
        data_en_d  = rd_act_q;
        data_d     = rd_act_q ? (rd_byte ^ 8'h80) : 8'h00;

        if (accept) begin
            s0_px_d   = RGB_Data;
            s0_bank_d = fill_ptr_q;
            s0_addr_d = wr_cnt_q;
            st_d[fill_ptr_q] = B_FILLING;
            wr_cnt_d = wr_cnt_q + 7'd1;
            if (wr_cnt_q == 7'd127) begin
                fill_ptr_d = ~fill_ptr_q;
            end
        end

        if (s2_vld_q && (s2_addr_q == 7'd127)) begin
            st_d[s2_bank_q] = B_FULL;
        end

        if (rd_act_q) begin
            rd_cnt_d = rd_cnt_q + 8'd1;
            if (rd_cnt_q == 8'd255) begin
                rd_act_d = 1'b0;
                done_d   = 1'b1;
                rd_ptr_d = ~rd_ptr_q;
                st_d[rd_ptr_q] = B_FREE;
            end
        end else if (st_q[rd_ptr_q] == B_FULL) begin
            rd_act_d = 1'b1;
            rd_cnt_d = 8'd0;
            st_d[rd_ptr_q] = B_DRAIN;
        end
    end

    always_ff @(posedge clock) begin
        if (s2_vld_q) begin
            y_mem[s2_bank_q][s2_addr_q] <= s2_y_q;
            if (s2_addr_q[0]) begin
                cb_mem[s2_bank_q][s2_addr_q[6:1]] <= s2_cb_q;
                cr_mem[s2_bank_q][s2_addr_q[6:1]] <= s2_cr_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            st_q[0]    <= B_FREE;
            st_q[1]    <= B_FREE;
            fill_ptr_q <= 1'b0;
            wr_cnt_q   <= 7'd0;
            s0_vld_q   <= 1'b0;
            s0_px_q    <= 16'd0;
            s0_bank_q  <= 1'b0;
            s0_addr_q  <= 7'd0;
            s1_vld_q   <= 1'b0;
            s1_bank_q  <= 1'b0;
            s1_addr_q  <= 7'd0;
            s1_yr_q    <= 16'd0;
            s1_yg_q    <= 16'd0;
            s1_yb_q    <= 16'd0;
            s1_br_q    <= 16'd0;
            s1_bg_q    <= 16'd0;
            s1_bb_q    <= 16'd0;
            s1_rr_q    <= 16'd0;
            s1_rg_q    <= 16'd0;
            s1_rb_q    <= 16'd0;
            s2_vld_q   <= 1'b0;
            s2_bank_q  <= 1'b0;
            s2_addr_q  <= 7'd0;
            s2_y_q     <= 8'd0;
            s2_cb_q    <= 8'd0;
            s2_cr_q    <= 8'd0;
            ev_cb_q    <= 8'd0;
            ev_cr_q    <= 8'd0;
            rd_ptr_q   <= 1'b0;
            rd_act_q   <= 1'b0;
            rd_cnt_q   <= 8'd0;
            data_en_q  <= 1'b0;
            data_q     <= 8'd0;
            done_q     <= 1'b0;
        end else begin
            st_q       <= st_d;
            fill_ptr_q <= fill_ptr_d;
            wr_cnt_q   <= wr_cnt_d;
            s0_vld_q   <= s0_vld_d;
            s0_px_q    <= s0_px_d;
            s0_bank_q  <= s0_bank_d;
            s0_addr_q  <= s0_addr_d;
            s1_vld_q   <= s1_vld_d;
            s1_bank_q  <= s1_bank_d;
            s1_addr_q  <= s1_addr_d;
            s1_yr_q    <= s1_yr_d;
            s1_yg_q    <= s1_yg_d;
            s1_yb_q    <= s1_yb_d;
            s1_br_q    <= s1_br_d;
            s1_bg_q    <= s1_bg_d;
            s1_bb_q    <= s1_bb_d;
            s1_rr_q    <= s1_rr_d;
            s1_rg_q    <= s1_rg_d;
            s1_rb_q    <= s1_rb_d;
            s2_vld_q   <= s2_vld_d;
            s2_bank_q  <= s2_bank_d;
            s2_addr_q  <= s2_addr_d;
            s2_y_q     <= s2_y_d;
            s2_cb_q    <= s2_cb_d;
            s2_cr_q    <= s2_cr_d;
            ev_cb_q    <= ev_cb_d;
            ev_cr_q    <= ev_cr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_act_q   <= rd_act_d;
            rd_cnt_q   <= rd_cnt_d;
            data_en_q  <= data_en_d;
            data_q     <= data_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_rgb565_to_ycbcr_packer.sv
// Scoreboard bench for rgb565_to_ycbcr_packer: integer reference model,
// queued expectations, independent output monitor.
module tb_rgb565_to_ycbcr_packer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        RGB_en = 1'b0;
    logic [15:0] RGB_Data = 16'd0;
    logic        pixel_ready;
    logic        compress_data_en;
    logic [7:0]  compress_data;
    logic        block_done;

    rgb565_to_ycbcr_packer dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .RGB_en           (RGB_en),
        .RGB_Data         (RGB_Data),
        .pixel_ready      (pixel_ready),
        .compress_data_en (compress_data_en),
        .compress_data    (compress_data),
        .block_done       (block_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc++;

    logic [7:0]  exp_q[$];
    logic [15:0] blk_pix[$];
    logic [7:0]  out_log[$];
    int          gaps[$];
    int n_cmp = 0;
    int n_bad = 0;
    int byte_idx = 0;
    bit prev_en = 0;
    int idle_run = 0;
    bit first_armed = 0;
    int first_cyc = 0;
    int last_acc = 0;
    bit saw_ready_low = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // Reference conversion straight from the BT.601 integer formulas
    task automatic conv(input logic [15:0] p,
                        output int y, output int cb, output int cr);
        int r5, g6, b5, r, g, b;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r = r5 * 8 + r5 / 4;
        g = g6 * 4 + g6 / 16;
        b = b5 * 8 + b5 / 4;
        y  = clampi(((66 * r + 129 * g + 25 * b + 128) >>> 8) + 16, 16, 235);
        cb = clampi(((-38 * r - 74 * g + 112 * b + 128) >>> 8) + 128, 16, 240);
        cr = clampi(((112 * r - 94 * g - 18 * b + 128) >>> 8) + 128, 16, 240);
    endtask

    task automatic model_accept(input logic [15:0] p);
        int ys[128];
        int cbs[128];
        int crs[128];
        blk_pix.push_back(p);
        if (blk_pix.size() == 128) begin
            for (int i = 0; i < 128; i++) conv(blk_pix[i], ys[i], cbs[i], crs[i]);
            for (int i = 0; i < 128; i++) exp_q.push_back(8'(ys[i] ^ 128));
            for (int k = 0; k < 64; k++)
                exp_q.push_back(8'(((cbs[2*k] + cbs[2*k+1] + 1) / 2) ^ 128));
            for (int k = 0; k < 64; k++)
                exp_q.push_back(8'(((crs[2*k] + crs[2*k+1] + 1) / 2) ^ 128));
            blk_pix.delete();
        end
    endtask

    task automatic send_pixel(input logic [15:0] p, input int en_pct);
        int guard;
        bit done;
        guard = 0;
        done = 0;
        while (!done) begin
            @(negedge clock);
            RGB_Data = p;
            RGB_en = ($urandom_range(99) < en_pct);
            if (!pixel_ready) saw_ready_low = 1;
            if (RGB_en && pixel_ready) begin
                done = 1;
                model_accept(p);
                last_acc = cyc + 1;
            end
            guard++;
            if (guard > 3000 && !done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL send_timeout: pixel_ready stuck low, needed 1");
                done = 1;
            end
        end
    endtask

    task automatic stop_input();
        @(negedge clock);
        RGB_en = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || compress_data_en) && guard < 4000) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d bytes outstanding, needed 0",
                     exp_q.size());
        end
        repeat (4) @(negedge clock);
    endtask

    // Output monitor / scoreboard
    always @(negedge clock) begin
        if (!reset_n) begin
            byte_idx = 0;
            prev_en = 0;
            idle_run = 0;
        end else begin
            if (compress_data_en) begin
                if (!prev_en) begin
                    gaps.push_back(idle_run);
                    if (first_armed) begin
                        first_cyc = cyc;
                        first_armed = 0;
                    end
                end
                idle_run = 0;
                out_log.push_back(compress_data);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_byte: got 0x%0h with nothing expected",
                             compress_data);
                end else begin
                    check("data", int'(compress_data), int'(exp_q.pop_front()));
                end
                check("block_done", int'(block_done), int'(byte_idx == 255));
                byte_idx = (byte_idx + 1) % 256;
            end else begin
                idle_run++;
                if (block_done) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL done_idle: block_done 1 without data, needed 0");
                end
            end
            prev_en = compress_data_en;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [15:0] arr[128];
    logic [7:0]  log_a[$];
    int diffs;
    int guard;

    initial begin
        repeat (3) @(negedge clock);
        check("rst_ready", int'(pixel_ready), 1);
        check("rst_en", int'(compress_data_en), 0);
        check("rst_data", int'(compress_data), 0);
        check("rst_done", int'(block_done), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        // White block at full rate
        out_log.delete();
        first_armed = 1;
        for (int i = 0; i < 128; i++) send_pixel(16'hFFFF, 100);
        stop_input();
        wait_idle();
        check("white_latency", first_cyc - last_acc, 5);
        check("white_count", out_log.size(), 256);
        if (out_log.size() == 256) begin
            check("white_y0", int'(out_log[0]), 'h6B);
            check("white_y127", int'(out_log[127]), 'h6B);
            check("white_cb0", int'(out_log[128]), 'h00);
            check("white_cr63", int'(out_log[255]), 'h00);
        end

        // Known pixel pairs, then random fill
        out_log.delete();
        for (int i = 0; i < 128; i++) arr[i] = 16'($urandom);
        arr[0] = 16'hF800; arr[1] = 16'h0000;
        arr[2] = 16'hF800; arr[3] = 16'hF800;
        arr[4] = 16'h0000; arr[5] = 16'h0000;
        for (int i = 0; i < 128; i++) send_pixel(arr[i], 100);
        stop_input();
        wait_idle();
        check("pat_count", out_log.size(), 256);
        if (out_log.size() == 256) begin
            check("red_y", int'(out_log[0]), 'hD2);
            check("black_y", int'(out_log[1]), 'h90);
            check("mix_cb", int'(out_log[128]), 'hED);
            check("mix_cr", int'(out_log[192]), 'h38);
            check("red_cb", int'(out_log[129]), 'hDA);
            check("red_cr", int'(out_log[193]), 'h70);
            check("black_cb", int'(out_log[130]), 'h00);
            check("black_cr", int'(out_log[194]), 'h00);
        end

        // Three blocks back-to-back with RGB_en held high
        out_log.delete();
        gaps.delete();
        saw_ready_low = 0;
        for (int i = 0; i < 384; i++) send_pixel(16'($urandom), 100);
        stop_input();
        wait_idle();
        check("bp_ready_low", int'(saw_ready_low), 1);
        check("bp_count", out_log.size(), 768);
        check("bp_bursts", gaps.size(), 3);
        if (gaps.size() == 3) begin
            check("bp_gap1", gaps[1], 1);
            check("bp_gap2", gaps[2], 1);
        end

        // Same block gap-free and throttled must match
        for (int i = 0; i < 128; i++) arr[i] = 16'($urandom);
        out_log.delete();
        for (int i = 0; i < 128; i++) send_pixel(arr[i], 100);
        stop_input();
        wait_idle();
        log_a = out_log;
        out_log.delete();
        for (int i = 0; i < 128; i++) send_pixel(arr[i], 35);
        stop_input();
        wait_idle();
        check("thr_count", out_log.size(), 256);
        diffs = 0;
        if (out_log.size() == 256 && log_a.size() == 256)
            for (int i = 0; i < 256; i++) if (out_log[i] != log_a[i]) diffs++;
        check("thr_same", diffs, 0);

        // Reset mid-drain with a partial block pending
        for (int i = 0; i < 178; i++) send_pixel(16'($urandom), 100);
        stop_input();
        guard = 0;
        while (!compress_data_en && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        check("rst_drain_started", int'(compress_data_en), 1);
        repeat (20) @(posedge clock);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        blk_pix.delete();
        #1;
        check("mid_rst_en", int'(compress_data_en), 0);
        check("mid_rst_ready", int'(pixel_ready), 1);
        check("mid_rst_done", int'(block_done), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        out_log.delete();
        for (int i = 0; i < 128; i++) send_pixel(16'($urandom), 100);
        stop_input();
        wait_idle();
        repeat (300) @(negedge clock);
        check("post_rst_count", out_log.size(), 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
